mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit with HI/LO registers for the MIPS datapath. It sits directly downstream of the execute-stage operand registers and consumes their rs/rt values when a MULT/MULTU/DIV/DIVU is issued. It produces a 64-bit product or a quotient/remainder pair in HI/LO, which the datapath reads via MFHI/MFLO. Operations take a fixed 33 cycles; `busy` tells the hazard logic to stall.

## Interface
- N, 32, operand width; HI/LO are N bits each; only 32 is supported.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  issue pulse; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  in  N  rs operand (multiplicand / dividend); sampled with start
- b  in  N  rt operand (multiplier / divisor); sampled with start
- mthi  in  1  write `wdata` into HI; honoured only in IDLE
- mtlo  in  1  write `wdata` into LO; honoured only in IDLE
- wdata  in  N  MTHI/MTLO data
- hi  out  N  HI register
- lo  out  N  LO register
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; `hi`/`lo` hold the new result in that cycle

## Operation
- Reset: all state is set on the clk edge where reset=1. State=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
- Reset mid-operation aborts the operation. No done pulse is issued, and HI/LO are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when start=1. Latch op, |a| and |b| (magnitudes for signed ops, raw values for unsigned ops), and the result sign flags. Clear the counter.
  - RUN lasts exactly 32 cycles. Each cycle is one shift-add multiply step or one restoring divide step, using a 64-bit working register and a 6-bit counter. RUN→DONE when counter=31.
  - On the RUN→DONE edge, HI/LO are loaded with the sign-corrected result.
  - DONE→IDLE unconditionally after 1 cycle.
- Multiply: {hi,lo} = a*b as a full 64-bit product, signed (MULT) or unsigned (MULTU). The signed result is negated when sign(a)≠sign(b).
- Divide: lo = quotient, hi = remainder.
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
- Defined boundary results:
  - divide by zero (b=0): lo=0xFFFFFFFF, hi=a, for both DIV and DIVU.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Illegal-time requests:
  - start while busy or in DONE is ignored, with no queueing. The issuer must wait for busy=0 and done=0.
  - mthi/mtlo outside IDLE are ignored.
- Simultaneous events in IDLE:
  - start together with mthi or mtlo: start wins and the write is dropped.
  - mthi and mtlo together: both registers are written.
- HI/LO change only on reset, on an IDLE mthi/mtlo write, or on the RUN→DONE edge. They hold their old values throughout RUN.

## Timing
- start sampled at the edge ending cycle T → busy=1 in cycles T+1..T+32. busy is a registered output.
- Result appears in cycle T+33: done=1, busy=0, hi/lo valid. Latency = 33 cycles from start to done.
- Earliest next start is accepted in cycle T+34 (back in IDLE). Throughput is 1 operation per 34 cycles.
- mthi/mtlo in IDLE cycle T → hi/lo updated from cycle T+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy for 32 cycles, done in cycle T+33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (−3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=7 → lo=14, hi=2.
- Boundary divides, each with done after 33 cycles:
  - DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Control hazards, run in this order:
  - mthi wdata=0x1234 in IDLE → hi=0x1234 next cycle.
  - start MULTU 3*4, then in cycle T+5 assert start and mtlo wdata=0xAAAA → both ignored; hi stays 0x1234 until the result.
  - Result: hi=0, lo=12.
  - Start another op, assert reset in cycle T+10 → busy=0, hi=lo=0 next cycle, and no done pulse follows.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Bus between the execute stage and the multiply/divide unit.
// master: datapath side; drives issue (start/op/a/b) and MTHI/MTLO (mthi/mtlo/wdata),
//         reads hi/lo/busy/done.
// slave:  mult_div_unit side.
interface mult_div_unit_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [N-1:0] wdata;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// A MULT/MULTU/DIV/DIVU issued in IDLE runs 32 shift-add or restoring-divide steps on
// operand magnitudes, then sign-corrects and loads HI/LO on the last step.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; aborts any operation and clears HI/LO
//   bus    mult_div_unit_if.slave: start/op/a/b issue, mthi/mtlo/wdata writes,
//          hi/lo/busy/done registered outputs
module mult_div_unit #(
    parameter int unsigned N = 32
) (
    input logic           clk,
    input logic           reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [5:0] LastStep = 6'(N - 1);

    state_e         r_state;
    logic           r_is_div;
    logic           r_neg_main;  // negate product (mul) or quotient (div)
    logic           r_neg_rem;   // negate remainder (div only)
    logic [N-1:0]   r_b;
    logic [2*N-1:0] r_work;
    logic [5:0]     r_cnt;
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic           r_busy;
    logic           r_done;

    // Operand magnitudes and signs at issue time; op[0]=1 selects the unsigned ops
    logic           w_signed;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic           w_b_zero;

    // One iteration step
    logic [N:0]     w_mul_sum;
    logic [2*N-1:0] w_mul_next;
    logic [N:0]     w_div_rem;
    logic [N-1:0]   w_div_diff;
    logic           w_div_ge;
    logic [2*N-1:0] w_div_next;
    logic [2*N-1:0] w_step;

    // Sign-corrected results from the final step
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quot;
    logic [N-1:0]   w_rem;
    logic [N-1:0]   w_res_hi;
    logic [N-1:0]   w_res_lo;

    always_comb begin
        w_signed = ~bus.op[0];
        w_a_neg  = w_signed & bus.a[N-1];
        w_b_neg  = w_signed & bus.b[N-1];
        w_a_mag  = w_a_neg ? -bus.a : bus.a;
        w_b_mag  = w_b_neg ? -bus.b : bus.b;
        w_b_zero = (bus.b == '0);
    end

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current multiplier
        // bit (LSB of the working register) is set, then shift right with the carry.
        w_mul_sum  = {1'b0, r_work[2*N-1:N]} + (r_work[0] ? {1'b0, r_b} : {(N + 1){1'b0}});
        w_mul_next = {w_mul_sum, r_work[N-1:1]};

        // Restoring divide: upper half is the partial remainder, lower half shifts the
        // dividend out and the quotient in. The remainder stays below the divisor, so
        // the N-bit difference is exact whenever the subtraction is taken.
        w_div_rem  = {r_work[2*N-1:N], r_work[N-1]};
        w_div_ge   = (w_div_rem >= {1'b0, r_b});
        w_div_diff = w_div_rem[N-1:0] - r_b;
        w_div_next = w_div_ge ? {w_div_diff, r_work[N-2:0], 1'b1}
                              : {w_div_rem[N-1:0], r_work[N-2:0], 1'b0};

        w_step     = r_is_div ? w_div_next : w_mul_next;
    end

    always_comb begin
        w_prod   = r_neg_main ? -w_step : w_step;
        w_quot   = r_neg_main ? -w_step[N-1:0] : w_step[N-1:0];
        w_rem    = r_neg_rem ? -w_step[2*N-1:N] : w_step[2*N-1:N];
        w_res_hi = r_is_div ? w_rem : w_prod[2*N-1:N];
        w_res_lo = r_is_div ? w_quot : w_prod[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b        <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        // start beats a same-cycle MTHI/MTLO, which is dropped
                        r_state  <= StRun;
                        r_busy   <= 1'b1;
                        r_is_div <= bus.op[1];
                        // Divide by zero keeps an all-ones quotient, so never negate it
                        r_neg_main <= (w_a_neg ^ w_b_neg) & ~(bus.op[1] & w_b_zero);
                        r_neg_rem  <= w_a_neg;
                        r_b      <= w_b_mag;
                        r_work   <= {{N{1'b0}}, w_a_mag};
                        r_cnt    <= '0;
                    end else begin
                        if (bus.mthi) r_hi <= bus.wdata;
                        if (bus.mtlo) r_lo <= bus.wdata;
                    end
                end
                StRun: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_cnt == LastStep) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule
